// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream packet generator: emits NUM_PKTS deterministic packets (or an
// endless stream when NUM_PKTS is 0) with a fixed inter-packet gap. Every byte
// is derived from the packet index and byte offset, so a receiver can check
// the stream without a reference copy.
module nf10_axis_pkt_gen #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned PKT_LEN              = 64,
  parameter int unsigned NUM_PKTS             = 4,
  parameter int unsigned IFG_CYCLES           = 2,
  parameter logic [7:0]  SRC_PORT             = 8'h01,
  parameter logic [7:0]  DST_PORT             = 8'h04
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              enable,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [7:0]                        counter,
  output logic                              activity_send,
  output logic                              done
);

  localparam int unsigned Bytes = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned Beats = (PKT_LEN + Bytes - 1) / Bytes;
  localparam int unsigned LastB = PKT_LEN - (Beats - 1) * Bytes;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [15:0] PktLen16 = PKT_LEN[15:0];

  function automatic logic is_last(input logic [15:0] beat);
    return (32'(beat) == Beats - 1);
  endfunction

  // Byte lane k of beat b carries (seq + b*Bytes + k) mod 256; lanes past the
  // packet end are zero.
  function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] beat_data(input logic [7:0]  seq8,
                                                               input logic [15:0] beat);
    logic [7:0] base;
    logic       last;
    beat_data = '0;
    base      = seq8 + 8'(32'(beat) * Bytes);
    last      = is_last(beat);
    for (int k = 0; k < int'(Bytes); k++) begin
      if (!last || k < int'(LastB)) beat_data[8*k +: 8] = base + 8'(k);
    end
  endfunction

  function automatic logic [Bytes-1:0] beat_strb(input logic [15:0] beat);
    beat_strb = '1;
    if (is_last(beat)) begin
      for (int k = 0; k < int'(Bytes); k++) begin
        if (k >= int'(LastB)) beat_strb[k] = 1'b0;
      end
    end
  endfunction

  logic [1:0]                       state_q, state_d;
  logic [15:0]                      seq_q, seq_d;
  logic [15:0]                      beat_q, beat_d;
  logic [31:0]                      gap_q, gap_d;
  logic [7:0]                       counter_q, counter_d;
  logic                             act_q, act_d;
  logic                             done_q, done_d;
  logic                             tvalid_q, tvalid_d;
  logic                             tlast_q, tlast_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [Bytes-1:0]                 tstrb_q, tstrb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;

  logic        load;
  logic [15:0] load_seq;
  logic [15:0] load_beat;

  // Next-state: FSM plus registered beat outputs, loaded only when a new beat
  // is presented so they stay frozen while the sink stalls.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    counter_d = counter_q;
    act_d     = 1'b0;
    done_d    = done_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    tstrb_d   = tstrb_q;
    tuser_d   = tuser_q;
    load      = 1'b0;
    load_seq  = seq_q;
    load_beat = '0;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSend;
          beat_d  = '0;
          load    = 1'b1;
        end
      end
      StSend: begin
        if (tvalid_q && m_axis_tready) begin
          if (tlast_q) begin
            seq_d     = seq_q + 16'd1;
            counter_d = counter_q + 8'd1;
            act_d     = 1'b1;
            beat_d    = '0;
            if (NUM_PKTS != 0 && 32'(seq_q) + 32'd1 == NUM_PKTS) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (IFG_CYCLES != 0) begin
              state_d = StGap;
              gap_d   = '0;
            end else if (enable) begin
              load     = 1'b1;
              load_seq = seq_q + 16'd1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d    = beat_q + 16'd1;
            load      = 1'b1;
            load_beat = beat_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (gap_q == 32'(IFG_CYCLES - 1)) begin
          if (enable) begin
            state_d = StSend;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      tvalid_d       = 1'b1;
      tdata_d        = beat_data(load_seq[7:0], load_beat);
      tstrb_d        = beat_strb(load_beat);
      tlast_d        = is_last(load_beat);
      tuser_d        = '0;
      tuser_d[31:0]  = {DST_PORT, SRC_PORT, PktLen16};
    end else if (state_d != StSend) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tdata_d  = '0;
      tstrb_d  = '0;
      tuser_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      counter_q <= '0;
      act_q     <= 1'b0;
      done_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tstrb_q   <= '0;
      tuser_q   <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      counter_q <= counter_d;
      act_q     <= act_d;
      done_q    <= done_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      tstrb_q   <= tstrb_d;
      tuser_q   <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign counter       = counter_q;
  assign activity_send = act_q;
  assign done          = done_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed bench for nf10_axis_pkt_gen: default config, PKT_LEN=70 config and
// an endless back-to-back config, each on its own instance with a shared clock.
module tb_nf10_axis_pkt_gen;

  logic aclk;
  logic aresetn;

  logic en0, rdy0, en1, rdy1, en2, rdy2;

  logic [255:0] tdata0, tdata1, tdata2;
  logic [31:0]  tstrb0, tstrb1, tstrb2;
  logic [127:0] tuser0, tuser1, tuser2;
  logic         tvalid0, tvalid1, tvalid2;
  logic         tlast0, tlast1, tlast2;
  logic [7:0]   cnt0, cnt1, cnt2;
  logic         act0, act1, act2;
  logic         done0, done1, done2;

  int checks = 0;
  int errors = 0;

  nf10_axis_pkt_gen u_dut (
    .aclk(aclk), .aresetn(aresetn), .enable(en0),
    .m_axis_tdata(tdata0), .m_axis_tstrb(tstrb0), .m_axis_tuser(tuser0),
    .m_axis_tvalid(tvalid0), .m_axis_tready(rdy0), .m_axis_tlast(tlast0),
    .counter(cnt0), .activity_send(act0), .done(done0)
  );

  nf10_axis_pkt_gen #(.PKT_LEN(70)) u_dut70 (
    .aclk(aclk), .aresetn(aresetn), .enable(en1),
    .m_axis_tdata(tdata1), .m_axis_tstrb(tstrb1), .m_axis_tuser(tuser1),
    .m_axis_tvalid(tvalid1), .m_axis_tready(rdy1), .m_axis_tlast(tlast1),
    .counter(cnt1), .activity_send(act1), .done(done1)
  );

  nf10_axis_pkt_gen #(.PKT_LEN(32), .NUM_PKTS(0), .IFG_CYCLES(0)) u_dut_inf (
    .aclk(aclk), .aresetn(aresetn), .enable(en2),
    .m_axis_tdata(tdata2), .m_axis_tstrb(tstrb2), .m_axis_tuser(tuser2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(rdy2), .m_axis_tlast(tlast2),
    .counter(cnt2), .activity_send(act2), .done(done2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference beat: byte (seq + offset) mod 256 for offsets inside the packet.
  function automatic logic [255:0] exp_data(input int seq, input int beat, input int len);
    logic [255:0] d;
    int idx;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      idx = beat * 32 + k;
      if (idx < len) d[8*k +: 8] = 8'((seq + idx) % 256);
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_strb(input int beat, input int len);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) if (beat * 32 + k < len) s[k] = 1'b1;
    return s;
  endfunction

  task automatic pulse_reset();
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
  endtask

  int ph, pk, acts, accepted;
  logic stall_prev, allv;
  logic [255:0] sv_data;
  logic [31:0]  sv_strb;
  logic         sv_last;

  initial begin
    en0 = 0; en1 = 0; en2 = 0;
    rdy0 = 1; rdy1 = 1; rdy2 = 1;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 256'(tvalid0), 256'(0));
    chk("rst_tdata", tdata0, 256'(0));
    chk("rst_tstrb", 256'(tstrb0), 256'(0));
    chk("rst_tuser", 256'(tuser0), 256'(0));
    chk("rst_tlast", 256'(tlast0), 256'(0));
    chk("rst_counter", 256'(cnt0), 256'(0));
    chk("rst_act", 256'(act0), 256'(0));
    chk("rst_done", 256'(done0), 256'(0));
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    step();
    chk("idle_tvalid", 256'(tvalid0), 256'(0));

    // Default config, free-flowing sink: period 4 (2 beats + 2 gap).
    en0 = 1;
    for (int i = 1; i <= 15; i++) begin
      step();
      ph = (i - 1) % 4;
      pk = (i - 1) / 4;
      chk("d_tvalid", 256'(tvalid0), 256'(ph < 2));
      if (ph < 2) begin
        chk("d_tdata", tdata0, exp_data(pk, ph, 64));
        chk("d_tstrb", 256'(tstrb0), 256'(32'hFFFF_FFFF));
        chk("d_tlast", 256'(tlast0), 256'(ph == 1));
        chk("d_tuser", 256'(tuser0), 256'(32'h0401_0040));
      end
      chk("d_act", 256'(act0), 256'(ph == 2));
      chk("d_counter", 256'(cnt0), 256'((i + 1) / 4));
      chk("d_done", 256'(done0), 256'(i == 15));
      if (i == 1) chk("d_p0b0_lo", 256'(tdata0[31:0]), 256'(32'h0302_0100));
      if (i == 2) chk("d_p0b1_hi", 256'(tdata0[255:224]), 256'(32'h3F3E_3D3C));
    end
    step();
    chk("d_done_hold", 256'(done0), 256'(1));
    chk("d_done_tvalid", 256'(tvalid0), 256'(0));
    chk("d_done_act", 256'(act0), 256'(0));
    en0 = 0;

    // PKT_LEN=70: 3 beats, last beat carries 6 bytes, period 5.
    en1 = 1;
    for (int i = 1; i <= 19; i++) begin
      step();
      ph = (i - 1) % 5;
      pk = (i - 1) / 5;
      chk("l70_tvalid", 256'(tvalid1), 256'(ph < 3));
      if (ph < 3) begin
        chk("l70_tdata", tdata1, exp_data(pk, ph, 70));
        chk("l70_tstrb", 256'(tstrb1), 256'(exp_strb(ph, 70)));
        chk("l70_tlast", 256'(tlast1), 256'(ph == 2));
      end
      chk("l70_counter", 256'(cnt1), 256'((i + 1) / 5));
      chk("l70_done", 256'(done1), 256'(i == 19));
      if (i == 3) chk("l70_last_strb", 256'(tstrb1), 256'(32'h0000_003F));
      if (i == 8) begin
        chk("l70_p1b2_lane0", 256'(tdata1[7:0]), 256'(8'h41));
        chk("l70_p1b2_lo", 256'(tdata1[47:0]), 256'(48'h4645_4443_4241));
        chk("l70_p1b2_hi0", 256'(tdata1[255:48]), 256'(0));
      end
    end
    en1 = 0;

    // Random backpressure on the default config.
    pulse_reset();
    en0 = 1;
    rdy0 = 0;
    acts = 0;
    accepted = 0;
    stall_prev = 0;
    sv_data = '0; sv_strb = '0; sv_last = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (act0) acts++;
      if (stall_prev) begin
        chk("bp_hold_valid", 256'(tvalid0), 256'(1));
        chk("bp_hold_data", tdata0, sv_data);
        chk("bp_hold_strb", 256'(tstrb0), 256'(sv_strb));
        chk("bp_hold_last", 256'(tlast0), 256'(sv_last));
      end
      if (done0) break;
      sv_data = tdata0; sv_strb = tstrb0; sv_last = tlast0;
      rdy0 = 1'($urandom_range(0, 1));
      if (tvalid0 && rdy0) begin
        chk("bp_beat", tdata0, exp_data(accepted / 2, accepted % 2, 64));
        chk("bp_last", 256'(tlast0), 256'(accepted % 2 == 1));
        accepted++;
      end
      stall_prev = tvalid0 && !rdy0;
    end
    chk("bp_done", 256'(done0), 256'(1));
    chk("bp_acts", 256'(acts), 256'(4));
    chk("bp_beats", 256'(accepted), 256'(8));
    chk("bp_counter", 256'(cnt0), 256'(4));
    rdy0 = 1;
    en0 = 0;

    // Endless back-to-back single-beat packets.
    en2 = 1;
    allv = 1;
    for (int i = 1; i <= 258; i++) begin
      step();
      if (!tvalid2) allv = 0;
    end
    chk("inf_tvalid_cont", 256'(allv), 256'(1));
    chk("inf_counter", 256'(cnt2), 256'(8'h01));
    chk("inf_done", 256'(done2), 256'(0));
    chk("inf_lane0", 256'(tdata2[7:0]), 256'(8'h01));
    chk("inf_tlast", 256'(tlast2), 256'(1));
    chk("inf_tstrb", 256'(tstrb2), 256'(32'hFFFF_FFFF));
    en2 = 0;

    // Enable dropped during beat 0 of packet 2.
    pulse_reset();
    step();
    en0 = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 9) begin
        chk("en_p2_valid", 256'(tvalid0), 256'(1));
        chk("en_p2_lane0", 256'(tdata0[7:0]), 256'(8'h02));
        en0 = 0;
      end
      if (i == 10) begin
        chk("en_p2_b1_valid", 256'(tvalid0), 256'(1));
        chk("en_p2_b1_last", 256'(tlast0), 256'(1));
      end
      if (i >= 11 && i <= 15) chk("en_idle_tvalid", 256'(tvalid0), 256'(0));
      if (i == 15) begin
        chk("en_idle_counter", 256'(cnt0), 256'(3));
        en0 = 1;
      end
      if (i == 16) begin
        chk("en_p3_valid", 256'(tvalid0), 256'(1));
        chk("en_p3_lane0", 256'(tdata0[7:0]), 256'(8'h03));
        chk("en_p3_tlast", 256'(tlast0), 256'(0));
      end
    end

    // Asynchronous reset mid-packet, between clock edges.
    #3 aresetn = 1'b0;
    #1;
    chk("ar_tvalid", 256'(tvalid0), 256'(0));
    chk("ar_counter", 256'(cnt0), 256'(0));
    chk("ar_done", 256'(done0), 256'(0));
    chk("ar_tdata", tdata0, 256'(0));
    #1 aresetn = 1'b1;
    step();
    chk("ar_restart_valid", 256'(tvalid0), 256'(1));
    chk("ar_restart_lo", 256'(tdata0[31:0]), 256'(32'h0302_0100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
